// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the execute-stage ALU.
//   alu_op_t    - operation select; encoding 4'hF is left unused and is
//                 treated as an undefined op (all-zero result, latency 1).
//   alu_state_t - control FSM states (MUL states only reachable when the
//                 unit is built with ALU_MUL_EN).
//   shamt_w()   - shift-amount width for a given data width.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD       = 4'd0,
        SUB       = 4'd1,
        AND       = 4'd2,
        OR        = 4'd3,
        XOR       = 4'd4,
        SRL       = 4'd5,
        SLL       = 4'd6,
        ROTR      = 4'd7,
        LDST_ADDR = 4'd8,
        BEQ       = 4'd9,
        BNE       = 4'd10,
        BEQZ      = 4'd11,
        BNEZ      = 4'd12,
        JUMP      = 4'd13,
        MUL       = 4'd14
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL      = 2'd1,
        ST_MUL_DONE = 2'd2
    } alu_state_t;

    function automatic int shamt_w(input int data_w);
        return $clog2(data_w);
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_if: operation-in / result-out handshake bundle of alu_exec_unit.
//   slave  - the ALU side (consumes in_*, op, operands; drives results).
//   master - the pipeline/driver side.
//   in_valid/in_ready   : operation handshake
//   op, src1, src2      : operation and operands
//   pc, br_offset       : branch base and offset
//   out_valid/out_ready : result handshake
//   result, overflow, branch_true, new_addr : registered results
interface alu_exec_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    import alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    alu_op_t           op;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] br_offset;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              overflow;
    logic              branch_true;
    logic [ADDR_W-1:0] new_addr;

    modport slave (
        input  in_valid, op, src1, src2, pc, br_offset, out_ready,
        output in_ready, out_valid, result, overflow, branch_true, new_addr
    );

    modport master (
        output in_valid, op, src1, src2, pc, br_offset, out_ready,
        input  in_ready, out_valid, result, overflow, branch_true, new_addr
    );

endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one partial product per cycle.
//   clk, rst_n : clock, async active-low reset
//   start      : latch a/b and begin (ignored semantics while busy are the
//                caller's concern; the ALU only starts it from IDLE)
//   busy       : iterations in progress
//   done       : high during the final iteration; product is valid the
//                cycle after done
//   product    : 2*DATA_W-bit unsigned a*b
// Only instantiated when the ALU is built with ALU_MUL_EN.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);
    localparam int CNT_W = shamt_w(DATA_W);

    logic [DATA_W-1:0]   mcand;
    logic [2*DATA_W-1:0] acc;     // {partial sum, remaining multiplier bits}
    logic [CNT_W-1:0]    cnt;
    logic                busy_q;
    logic [DATA_W:0]     sum;

    // Add the multiplicand into the upper half when the current multiplier
    // bit is set; the carry is kept so the right shift loses nothing.
    assign sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, mcand} : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            acc    <= {{DATA_W{1'b0}}, b};
            cnt    <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            acc <= {sum, acc[DATA_W-1:1]};
            cnt <= cnt + 1'b1;
            if (done) busy_q <= 1'b0;
        end
    end

    assign busy    = busy_q;
    assign done    = busy_q && (cnt == CNT_W'(DATA_W - 1));
    assign product = acc;

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked execute-stage ALU with registered outputs.
//   clk, rst_n : clock, async active-low reset
//   bus        : alu_exec_if.slave (operation in, result out)
// Single-cycle ops load the output registers on the edge that accepts them.
// Build option ALU_MUL_EN: adds the iterative multiplier (MUL takes
// DATA_W+1 cycles, in_ready low meanwhile). Without it MUL behaves as an
// undefined op (zeros, latency 1) and the FSM never leaves IDLE.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_exec_if.slave  bus
);
    localparam int SHAMT_W = shamt_w(DATA_W);

    alu_state_t state, state_nxt;
    logic       in_fire, is_mul, load_single, load_mul;
    logic       mul_done, mul_busy;
    logic [DATA_W-1:0] mul_res;
    logic              mul_ovf;

    logic [DATA_W-1:0] res_c;
    logic              ovf_c, bt_c;
    logic [ADDR_W-1:0] addr_c;

    logic              out_valid_q, ovf_q, bt_q;
    logic [DATA_W-1:0] result_q;
    logic [ADDR_W-1:0] addr_q;

    logic [SHAMT_W-1:0]  shamt;
    logic [DATA_W-1:0]   sum, diff;
    logic [2*DATA_W-1:0] rot;

    assign shamt = bus.src2[SHAMT_W-1:0];
    assign sum   = bus.src1 + bus.src2;
    assign diff  = bus.src1 - bus.src2;
    // Rotating the doubled word keeps amount 0 returning src1 unchanged.
    assign rot   = {bus.src1, bus.src1} >> shamt;

    always_comb begin
        res_c  = '0;
        ovf_c  = 1'b0;
        bt_c   = 1'b0;
        addr_c = '0;
        case (bus.op)
            ADD: begin
                res_c = sum;
                ovf_c = (bus.src1[DATA_W-1] == bus.src2[DATA_W-1]) &&
                        (sum[DATA_W-1] != bus.src1[DATA_W-1]);
            end
            LDST_ADDR: res_c = sum;
            SUB: begin
                res_c = diff;
                ovf_c = (bus.src1[DATA_W-1] != bus.src2[DATA_W-1]) &&
                        (diff[DATA_W-1] != bus.src1[DATA_W-1]);
            end
            AND:  res_c = bus.src1 & bus.src2;
            OR:   res_c = bus.src1 | bus.src2;
            XOR:  res_c = bus.src1 ^ bus.src2;
            SRL:  res_c = bus.src1 >> shamt;
            SLL:  res_c = bus.src1 << shamt;
            ROTR: res_c = rot[DATA_W-1:0];
            BEQ:  begin bt_c = (bus.src1 == bus.src2); addr_c = bus.pc + bus.br_offset; end
            BNE:  begin bt_c = (bus.src1 != bus.src2); addr_c = bus.pc + bus.br_offset; end
            BEQZ: begin bt_c = (bus.src1 == '0);       addr_c = bus.pc + bus.br_offset; end
            BNEZ: begin bt_c = (bus.src1 != '0);       addr_c = bus.pc + bus.br_offset; end
            JUMP: begin bt_c = 1'b1;                   addr_c = bus.pc + bus.br_offset; end
            default: ;
        endcase
    end

    assign bus.in_ready = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign in_fire      = bus.in_valid && bus.in_ready;

`ifdef ALU_MUL_EN
    logic [2*DATA_W-1:0] product;

    assign is_mul = (bus.op == MUL);

    alu_mul_iter #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (in_fire && is_mul),
        .a       (bus.src1),
        .b       (bus.src2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    assign mul_res = product[DATA_W-1:0];
    assign mul_ovf = |product[2*DATA_W-1:DATA_W];
`else
    assign is_mul   = 1'b0;
    assign mul_busy = 1'b0;
    assign mul_done = 1'b0;
    assign mul_res  = '0;
    assign mul_ovf  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        load_single = 1'b0;
        load_mul    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_fire) begin
                    if (is_mul) state_nxt   = ST_MUL;
                    else        load_single = 1'b1;
                end
            end
            ST_MUL: begin
                // done marks the last iteration; the product settles on the
                // same edge that moves us to MUL_DONE.
                if (mul_done)      state_nxt = ST_MUL_DONE;
                else if (!mul_busy) state_nxt = ST_IDLE;
            end
            ST_MUL_DONE: begin
                load_mul  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A load only happens when the previous result is gone or leaving this
    // cycle (in_ready guarantees it; MUL entry already drained it).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            bt_q        <= 1'b0;
            addr_q      <= '0;
        end else if (load_single) begin
            out_valid_q <= 1'b1;
            result_q    <= res_c;
            ovf_q       <= ovf_c;
            bt_q        <= bt_c;
            addr_q      <= addr_c;
        end else if (load_mul) begin
            out_valid_q <= 1'b1;
            result_q    <= mul_res;
            ovf_q       <= mul_ovf;
            bt_q        <= 1'b0;
            addr_q      <= '0;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.result      = result_q;
    assign bus.overflow    = ovf_q;
    assign bus.branch_true = bt_q;
    assign bus.new_addr    = addr_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit (works with or without ALU_MUL_EN).
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int W = 32;
    localparam int A = 32;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_exec_if #(.DATA_W(W), .ADDR_W(A)) bus();

    alu_exec_unit #(.DATA_W(W), .ADDR_W(A)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        bt;
        logic [31:0] addr;
    } exp_t;

    int tests = 0;
    int fails = 0;

    // Transaction-level model of what the output registers must hold.
    bit   m_ov;
    exp_t m_out;
    int   m_busy;   // cycles until a pending multiply result appears
    exp_t m_pend;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_calc(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] pc,
                                      input logic [31:0] off);
        exp_t        e;
        longint      s;
        logic [31:0] r;
        logic [63:0] p;
        e = '0;
        s = 0;
        r = a;
        p = '0;
        case (op)
            ADD: begin
                e.res = a + b;
                s = longint'($signed(a)) + longint'($signed(b));
                e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            SUB: begin
                e.res = a - b;
                s = longint'($signed(a)) - longint'($signed(b));
                e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            LDST_ADDR: e.res = a + b;
            AND:  e.res = a & b;
            OR:   e.res = a | b;
            XOR:  e.res = a ^ b;
            SRL:  e.res = a >> (b % 32);
            SLL:  e.res = a << (b % 32);
            ROTR: begin
                repeat (int'(b % 32)) r = {r[0], r[31:1]};
                e.res = r;
            end
            BEQ:  begin e.bt = (a == b); e.addr = pc + off; end
            BNE:  begin e.bt = (a != b); e.addr = pc + off; end
            BEQZ: begin e.bt = (a == 0); e.addr = pc + off; end
            BNEZ: begin e.bt = (a != 0); e.addr = pc + off; end
            JUMP: begin e.bt = 1'b1;     e.addr = pc + off; end
            MUL: begin
                if (MUL_EN) begin
                    p = {32'b0, a} * {32'b0, b};
                    e.res = p[31:0];
                    e.ovf = (p[63:32] != 0);
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic bit m_in_ready();
        return (m_busy == 0) && (!m_ov || bus.out_ready);
    endfunction

    task automatic model_next();
        bit   load;
        bit   ofire;
        exp_t nv;
        exp_t e;
        load  = 1'b0;
        nv    = '0;
        ofire = m_ov && bus.out_ready;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                load = 1'b1;
                nv   = m_pend;
            end
        end else if (bus.in_valid && m_in_ready()) begin
            e = ref_calc(bus.op, bus.src1, bus.src2, bus.pc, bus.br_offset);
            if (MUL_EN && bus.op == MUL) begin
                m_busy = W + 1;
                m_pend = e;
            end else begin
                load = 1'b1;
                nv   = e;
            end
        end
        if (load) begin
            m_ov  = 1'b1;
            m_out = nv;
        end else if (ofire) begin
            m_ov = 1'b0;
        end
    endtask

    // One clock cycle: compare at the falling edge, advance the model with
    // the inputs that the next rising edge will see, return just after it.
    task automatic step();
        @(negedge clk);
        if (!rst_n) begin
            m_ov   = 1'b0;
            m_out  = '0;
            m_busy = 0;
        end
        chk("out_valid", bus.out_valid, m_ov);
        chk("in_ready", bus.in_ready, m_in_ready());
        if (m_ov || !rst_n) begin
            chk("result", bus.result, m_out.res);
            chk("overflow", bus.overflow, m_out.ovf);
            chk("branch_true", bus.branch_true, m_out.bt);
            chk("new_addr", bus.new_addr, m_out.addr);
        end
        if (rst_n) model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic [31:0] off);
        bus.op        = alu_op_t'(op);
        bus.src1      = a;
        bus.src2      = b;
        bus.pc        = pc;
        bus.br_offset = off;
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] off);
        set_in(op, a, b, pc, off);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'($urandom_range(0, 40));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   r;
        logic [3:0] rop;

        m_ov = 1'b0; m_out = '0; m_busy = 0; m_pend = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        set_in(ADD, 0, 0, 0, 0);

        // Pin the reference model to hand-computed values.
        e = ref_calc(ADD, 32'h7FFF_FFFF, 32'h1, 0, 0);
        chk("pin_add", {e.res, e.ovf}, {32'h8000_0000, 1'b1});
        e = ref_calc(SUB, 32'h8000_0000, 32'h1, 0, 0);
        chk("pin_sub", {e.res, e.ovf}, {32'h7FFF_FFFF, 1'b1});
        e = ref_calc(ROTR, 32'h1, 32'd33, 0, 0);
        chk("pin_rotr", e.res, 32'h8000_0000);
        e = ref_calc(BNE, 32'd5, 32'd5, 32'h100, 32'h20);
        chk("pin_bne", {e.bt, e.addr}, {1'b0, 32'h120});

        // Reset
        repeat (3) step();
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_result", bus.result, 32'h0);
        chk("rst_ready", bus.in_ready, 1'b1);
        rst_n = 1'b1;
        step();

        // Directed single-cycle ops
        send(ADD, 32'h7FFF_FFFF, 32'h1, 0, 0);
        chk("add_valid", bus.out_valid, 1'b1);
        chk("add_res", bus.result, 32'h8000_0000);
        chk("add_ovf", bus.overflow, 1'b1);
        send(SUB, 32'h8000_0000, 32'h1, 0, 0);
        chk("sub_res", bus.result, 32'h7FFF_FFFF);
        chk("sub_ovf", bus.overflow, 1'b1);
        send(ROTR, 32'h1, 32'd33, 0, 0);
        chk("rotr_res", bus.result, 32'h8000_0000);
        send(SRL, 32'hA5A5_0F0F, 32'd0, 0, 0);
        chk("srl0_res", bus.result, 32'hA5A5_0F0F);
        send(BNE, 32'd5, 32'd5, 32'h100, 32'h20);
        chk("bne_bt", bus.branch_true, 1'b0);
        chk("bne_addr", bus.new_addr, 32'h120);
        chk("bne_res", bus.result, 32'h0);
        send(JUMP, 32'd0, 32'd0, 32'h100, 32'h20);
        chk("jump_bt", bus.branch_true, 1'b1);
        send(4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h10, 32'h10);
        chk("undef_valid", bus.out_valid, 1'b1);
        chk("undef_zero", {bus.result, bus.overflow, bus.branch_true, bus.new_addr}, 65'h0);
        step();

        // Downstream stall, then back-to-back
        bus.out_ready = 1'b0;
        send(ADD, 32'd3, 32'd4, 0, 0);
        set_in(ADD, 32'd10, 32'd20, 0, 0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_ready", bus.in_ready, 1'b0);
            chk("stall_valid", bus.out_valid, 1'b1);
            chk("stall_res", bus.result, 32'd7);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(ADD, 32'(100 * i), 32'(i + 1), 0, 0);
            step();
            chk("b2b_valid", bus.out_valid, 1'b1);
            chk("b2b_res", bus.result, 32'(101 * i + 1));
        end
        bus.in_valid = 1'b0;
        step();

        // Multiply
        send(MUL, 32'h0001_0000, 32'h0001_0000, 0, 0);
`ifdef ALU_MUL_EN
        for (int k = 1; k <= W; k++) begin
            chk("mul_busy_ready", bus.in_ready, 1'b0);
            chk("mul_busy_valid", bus.out_valid, 1'b0);
            step();
        end
        chk("mul_last_ready", bus.in_ready, 1'b0);
        step();
`endif
        chk("mul_valid", bus.out_valid, 1'b1);
        chk("mul_res", bus.result, 32'h0);
        chk("mul_ovf", bus.overflow, MUL_EN);
        step();

        // Reset in the middle of a multiply
        send(MUL, 32'h1234, 32'h5678, 0, 0);
        repeat (9) step();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", bus.out_valid, 1'b0);
        chk("rst_mid_outs", {bus.result, bus.overflow, bus.branch_true, bus.new_addr}, 65'h0);
        chk("rst_mid_ready", bus.in_ready, 1'b1);
        step();
        step();
        rst_n = 1'b1;
        chk("post_rst_ready", bus.in_ready, 1'b1);
        repeat (40) step();

        // Random traffic
        for (int c = 0; c < 500; c++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4)      rop = 4'(MUL);
            else if (r < 8) rop = 4'hF;
            else            rop = 4'($urandom_range(0, 13));
            set_in(rop, rnd_val(), rnd_val(), 32'($urandom), 32'($urandom));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (40) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
